// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// 8N1 UART receiver: 16x oversampled, mid-bit sampling, LSB first, registered done strobe.
// Latency: 2 clk synchronizer + tick alignment; no backpressure, each byte is a 1-clk pulse.
module uart_rx #(
  parameter int NB_DATA  = 8,
  parameter int SB_TICK  = 16,
  parameter int OVERSAMP = 16
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_rx_done,
  output logic               o_frame_err
);

  localparam int S_MAX = (OVERSAMP > SB_TICK) ? OVERSAMP : SB_TICK;
  localparam int SW    = $clog2(S_MAX);
  localparam int NW    = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMP/2 - 1);
  localparam logic [SW-1:0] S_BIT  = SW'(OVERSAMP - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(NB_DATA - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             r_state, w_state_next;
  logic [SW-1:0]      r_s, w_s_next;
  logic [NW-1:0]      r_n, w_n_next;
  logic [NB_DATA-1:0] r_b, w_b_next;
  logic               r_armed, w_armed_next;
  logic               r_sync1, r_rx_s;
  logic [NB_DATA-1:0] r_data, w_data_next;
  logic               r_rx_done, w_done_next;
  logic               r_frame_err, w_ferr_next;

  always_ff @(posedge clk) begin
    if (!i_reset) begin
      r_state     <= IDLE;
      r_s         <= '0;
      r_n         <= '0;
      r_b         <= '0;
      r_armed     <= 1'b1;
      r_sync1     <= 1'b1;
      r_rx_s      <= 1'b1;
      r_data      <= '0;
      r_rx_done   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_s         <= w_s_next;
      r_n         <= w_n_next;
      r_b         <= w_b_next;
      r_armed     <= w_armed_next;
      r_sync1     <= i_rx;
      r_rx_s      <= r_sync1;
      r_data      <= w_data_next;
      r_rx_done   <= w_done_next;
      r_frame_err <= w_ferr_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_s_next     = r_s;
    w_n_next     = r_n;
    w_b_next     = r_b;
    w_armed_next = r_armed;
    w_data_next  = r_data;
    w_done_next  = 1'b0;
    w_ferr_next  = r_frame_err;
    case (r_state)
      IDLE: begin
        if (r_rx_s) w_armed_next = 1'b1;
        // Start edge is taken without waiting for a tick; a coincident tick is not counted.
        if (r_armed && !r_rx_s) begin
          w_state_next = START;
          w_s_next     = '0;
        end
      end
      START: begin
        if (i_tick) begin
          if (r_s == S_MID) begin
            w_s_next = '0;
            if (!r_rx_s) begin
              w_state_next = DATA;
              w_n_next     = '0;
            end else begin
              w_state_next = IDLE;
            end
          end else begin
            w_s_next = r_s + SW'(1);
          end
        end
      end
      DATA: begin
        if (i_tick) begin
          if (r_s == S_BIT) begin
            w_s_next = '0;
            w_b_next = {r_rx_s, r_b[NB_DATA-1:1]};
            if (r_n == N_LAST) w_state_next = STOP;
            else               w_n_next     = r_n + NW'(1);
          end else begin
            w_s_next = r_s + SW'(1);
          end
        end
      end
      STOP: begin
        if (i_tick) begin
          if (r_s == S_STOP) begin
            w_state_next = IDLE;
            w_s_next     = '0;
            w_data_next  = r_b;
            w_ferr_next  = ~r_rx_s;
            w_done_next  = 1'b1;
            // A low stop bit disarms so a break cannot retrigger until the line idles high.
            if (!r_rx_s) w_armed_next = 1'b0;
          end else begin
            w_s_next = r_s + SW'(1);
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign o_data      = r_data;
  assign o_rx_done   = r_rx_done;
  assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// Bench for uart_rx: tick every 4 clk (1 bit = 64 clk); scoreboard of expected bytes,
// plus a second receiver with two stop bits for the stop-length timing comparison.
module tb_uart_rx;
  localparam int BIT_CLK = 64;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap;
    logic       exp_ferr;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    int         start;
  } exp_t;

  logic       clk = 1'b0;
  logic       i_reset, i_tick, rx_a, rx_b, b_en;
  logic [7:0] data_a, data_b;
  logic       done_a, done_b, ferr_a, ferr_b;

  int   checks = 0, passes = 0;
  int   cyc = 0, tc = 0;
  int   n_done_a = 0, n_done_b = 0, exp_dones = 0;
  int   last_done_a = 0, last_done_b = 0, last_start = 0;
  logic prev_done_a = 1'b0;
  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[6];

  uart_rx u_dut_a (
    .clk(clk), .i_reset(i_reset), .i_tick(i_tick), .i_rx(rx_a),
    .o_data(data_a), .o_rx_done(done_a), .o_frame_err(ferr_a)
  );

  uart_rx #(.SB_TICK(32)) u_dut_b (
    .clk(clk), .i_reset(i_reset), .i_tick(i_tick), .i_rx(rx_b),
    .o_data(data_b), .o_rx_done(done_b), .o_frame_err(ferr_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    i_tick = 1'b0;
    forever begin
      @(negedge clk);
      tc = (tc + 1) % 4;
      i_tick = (tc == 0);
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: actual %0h required %0h", nm, act, req);
  endtask

  task automatic set_line(input logic v);
    rx_a = v;
    rx_b = b_en ? v : 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int gap,
                            input logic push, input logic ferr);
    exp_t e;
    last_start = cyc;
    if (push) begin
      e.data = d; e.ferr = ferr; e.start = cyc;
      sb.push_back(e);
      exp_dones++;
    end
    set_line(1'b0);
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      set_line(d[i]);
      repeat (BIT_CLK) @(negedge clk);
    end
    set_line(stop);
    repeat (BIT_CLK) @(negedge clk);
    set_line(1'b1);
    repeat (gap * BIT_CLK) @(negedge clk);
  endtask

  task automatic drain(input string nm);
    int k = 0;
    while (sb.size() != 0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check(nm, sb.size(), 0);
  endtask

  // Start edge to visible done: 2 sync + 1..4 clk tick alignment + 151 ticks + 1 register.
  always @(negedge clk) begin
    if (done_a) begin
      n_done_a++;
      last_done_a = cyc;
      check("done_width", prev_done_a, 1'b0);
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: actual data %0h, required no done", data_a);
      end else begin
        mon_e = sb.pop_front();
        check("rx_data", data_a, mon_e.data);
        check("rx_ferr", ferr_a, mon_e.ferr);
        if (mon_e.start >= 0) begin
          checks++;
          if (cyc - mon_e.start >= 608 && cyc - mon_e.start <= 611) passes++;
          else $display("FAIL latency: actual %0d required 608..611", cyc - mon_e.start);
        end
      end
    end
    prev_done_a = done_a;
    if (done_b) begin
      n_done_b++;
      last_done_b = cyc;
      check("b_data", data_b, 8'hC6);
      check("b_ferr", ferr_b, 1'b0);
    end
  end

  initial begin
    vecs[0] = '{8'h55, 1'b1, 2, 1'b0};
    vecs[1] = '{8'hA3, 1'b1, 0, 1'b0};
    vecs[2] = '{8'h00, 1'b1, 2, 1'b0};
    vecs[3] = '{8'h5A, 1'b0, 2, 1'b1};
    vecs[4] = '{8'hFF, 1'b1, 0, 1'b0};
    vecs[5] = '{8'h01, 1'b1, 2, 1'b0};

    i_reset = 1'b0; b_en = 1'b0; rx_a = 1'b1; rx_b = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_data", data_a, 8'h00);
    check("reset_done", done_a, 1'b0);
    check("reset_ferr", ferr_a, 1'b0);
    check("reset_data_b", data_b, 8'h00);
    i_reset = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);

    foreach (vecs[i]) send_frame(vecs[i].data, vecs[i].stop, vecs[i].gap, 1'b1, vecs[i].exp_ferr);
    drain("table_drain");

    // Glitch shorter than half a bit must be rejected.
    set_line(1'b0);
    repeat (20) @(negedge clk);
    set_line(1'b1);
    repeat (3 * BIT_CLK) @(negedge clk);
    check("glitch_no_done", n_done_a, exp_dones);
    send_frame(8'h3C, 1'b1, 2, 1'b1, 1'b0);
    drain("glitch_drain");

    // Low stop bit followed by a held-low line: one done, then no retrigger.
    send_frame(8'hF0, 1'b0, 0, 1'b1, 1'b1);
    set_line(1'b0);
    repeat (3 * BIT_CLK) @(negedge clk);
    check("break_one_done", n_done_a, exp_dones);
    set_line(1'b1);
    repeat (8 * BIT_CLK) @(negedge clk);
    check("break_no_retrigger", n_done_a, exp_dones);
    check("break_ferr_held", ferr_a, 1'b1);
    send_frame(8'h99, 1'b1, 2, 1'b1, 1'b0);
    drain("break_drain");

    // Reset a quarter into data bit 4 of 0x81. The line is still low afterwards, so the
    // receiver restarts there and samples bit5, bit6, bit7, stop, then idle: 0xFC, no error.
    fork
      send_frame(8'h81, 1'b1, 0, 1'b0, 1'b0);
      begin
        repeat (5 * BIT_CLK + 16) @(negedge clk);
        i_reset = 1'b0;
        @(negedge clk);
        check("midreset_data", data_a, 8'h00);
        check("midreset_ferr", ferr_a, 1'b0);
        i_reset = 1'b1;
        sb.push_back('{8'hFC, 1'b0, -1});
        exp_dones++;
      end
    join
    check("midreset_no_done", data_a, 8'h00);
    repeat (6 * BIT_CLK) @(negedge clk);
    drain("restart_drain");
    send_frame(8'h7E, 1'b1, 2, 1'b1, 1'b0);
    drain("post_reset_drain");

    // Start edge placed so the IDLE->START cycle carries a tick; compare 1 vs 2 stop bits.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      if (i_tick) break;
    end
    @(negedge clk);
    @(negedge clk);
    b_en = 1'b1;
    send_frame(8'hC6, 1'b1, 3, 1'b1, 1'b0);
    b_en = 1'b0;
    set_line(1'b1);
    drain("sb32_drain");
    check("tick_edge_latency", last_done_a - last_start, 611);
    check("sb32_done_count", n_done_b, 1);
    check("sb32_extra_delay", last_done_b - last_done_a, 64);

    check("total_dones", n_done_a, exp_dones);
    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
